// File: rtl/miriscv_data_ram.sv
`timescale 1ns/1ps
// miriscv_data_ram
// ----------------
// Word-organised data memory with a byte-write mask and a wait-state access
// model. A request is accepted in IDLE, optionally held in WAIT for
// WAIT_CYCLES edges, and completed with a one-cycle ready pulse in RESP.
// mem_busy_o stalls the core while an access is outstanding.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..65536)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   WAIT_CYCLES  wait states inserted before the response (0..15)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   mem_req_i    access request
//   mem_we_i     1 = write, 0 = read
//   mem_mask_i   byte enables, bit k covers bits [8k+7:8k]
//   mem_addr_i   byte address, bits [1:0] ignored
//   mem_data_i   write data (byte-lane replicated by the LSU)
//   mem_data_o   registered read data
//   mem_ready_o  registered one-cycle completion pulse
//   mem_busy_o   combinational stall request to the core
//   mem_err_o    (only with RAM_RANGE_ERR_EN) out-of-range pulse with ready
//
// Optional feature macro: RAM_RANGE_ERR_EN
//   Defined:   out-of-range accesses are flagged on mem_err_o, writes are
//              suppressed and reads return zero.
//   Undefined: addresses wrap modulo DEPTH_WORDS.
module miriscv_data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_mask_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o,
    output logic        mem_busy_o
`ifdef RAM_RANGE_ERR_EN
    ,
    output logic        mem_err_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SIZE_BYTES = 32'(4 * DEPTH_WORDS);
`ifdef RAM_RANGE_ERR_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       do_access;

    logic          lat_we;
    logic [3:0]    lat_mask;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          lat_err;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          in_err;

    logic          acc_we;
    logic [3:0]    acc_mask;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          acc_err;

    logic [31:0] mem [DEPTH_WORDS];

    // Offset from the base address. An address below BASE_ADDR wraps to a
    // huge unsigned offset, so a single compare covers both range limits.
    assign offset = mem_addr_i - BASE_ADDR;
    assign idx    = AW'(offset >> 2);
    assign in_err = RANGE_CHECK && (offset >= SIZE_BYTES);

    // With zero wait states the access happens on the accepting edge, so
    // the live inputs are used; otherwise the latched copy is used.
    always_comb begin
        acc_we    = lat_we;
        acc_mask  = lat_mask;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        acc_err   = lat_err;
        if (state == IDLE) begin
            acc_we    = mem_we_i;
            acc_mask  = mem_mask_i;
            acc_idx   = idx;
            acc_wdata = mem_data_i;
            acc_err   = in_err;
        end
    end

    // Next-state logic and access strobe.
    always_comb begin
        state_next = state;
        count_next = count;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        count_next = 4'(WAIT_CYCLES);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_busy_o = ((state == IDLE) && mem_req_i) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Request capture; only meaningful between acceptance and the access,
    // so these registers need no reset.
    always_ff @(posedge clk) begin
        if (!reset && (state == IDLE) && mem_req_i) begin
            lat_we    <= mem_we_i;
            lat_mask  <= mem_mask_i;
            lat_idx   <= idx;
            lat_wdata <= mem_data_i;
            lat_err   <= in_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data_o  <= 32'h0000_0000;
            mem_ready_o <= 1'b0;
        end else begin
            mem_ready_o <= do_access;
            if (do_access && !acc_we) begin
                mem_data_o <= acc_err ? 32'h0000_0000 : mem[acc_idx];
            end
        end
    end

    // Array write; a reset on the access edge discards the pending write.
    always_ff @(posedge clk) begin
        if (!reset && do_access && acc_we && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_mask[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

`ifdef RAM_RANGE_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err_o <= 1'b0;
        end else begin
            mem_err_o <= do_access && acc_err;
        end
    end
`endif

endmodule

// File: doc/miriscv_data_ram.md
Name: miriscv_data_ram

Overview:
Word-organised data memory with byte-write mask that sits directly downstream of the load/store unit on the memory protocol (req/we/mask/addr/wdata in, rdata out). It adds a configurable wait-state access model with a ready/busy handshake, so the core stalls the PC while an access is outstanding. The LSU consumes mem_data_o and forwards mem_busy_o into the core's PC-enable logic.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 4..65536
BASE_ADDR, 32'h0000_0000, byte address of word 0; 4-byte aligned
WAIT_CYCLES, 1, wait states inserted before response; 0..15

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_req_i  input  1  access request
mem_we_i  input  1  1 = write, 0 = read
mem_mask_i  input  4  byte enables; bit k enables bits [8k+7:8k]
mem_addr_i  input  32  byte address; bits [1:0] ignored
mem_data_i  input  32  write data, already byte-lane replicated by the LSU
mem_data_o  output  32  read data, full word, registered
mem_ready_o  output  1  one-cycle completion pulse, registered
mem_busy_o  output  1  stall request to core, combinational

Behaviour:
- Word index = (mem_addr_i - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits (wraps modulo DEPTH_WORDS).
- FSM states: IDLE, WAIT, RESP. Reset: state = IDLE, wait counter = 0, mem_data_o = 0, mem_ready_o = 0. Array contents are not reset.
- IDLE: on an edge with mem_req_i = 1, latch we/mask/index/wdata.
  - WAIT_CYCLES = 0: perform the access on that edge and go to RESP.
  - Otherwise: counter = WAIT_CYCLES and go to WAIT.
  - mem_req_i = 0: stay in IDLE.
- WAIT: counter decrements each edge. On the edge where counter = 1, perform the access from the latched values and go to RESP.
- Access:
  - Write: byte k of the array word updated only if mask[k] = 1. Mask 4'b0000 completes with no change. mem_data_o holds its previous value.
  - Read: mem_data_o = full array word; mask ignored.
- RESP: mem_ready_o = 1 for exactly this cycle. Unconditional transition to IDLE; mem_req_i in RESP is ignored. A back-to-back request is accepted in the following IDLE cycle.
- Latency: request accepted at end of cycle 0, so mem_ready_o is high in cycle WAIT_CYCLES+1.
- mem_busy_o = (state==IDLE & mem_req_i) | (state==WAIT). It is 0 in RESP, so the core advances in the ready cycle.
- Inputs are sampled only at acceptance. Changes to them during WAIT have no effect.
- Reset in WAIT or RESP: return to IDLE, pending write discarded (array untouched), outputs return to reset values on the next cycle.
- Reset and mem_req_i asserted together: reset wins, request not accepted.

Optional Feature:
RAM_RANGE_ERR_EN
- Defined:
  - Adds output port mem_err_o (1 bit, reset 0).
  - A request with byte address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) is still handshaken with normal latency.
  - The out-of-range write is suppressed; an out-of-range read returns mem_data_o = 32'h0000_0000.
  - mem_err_o pulses high together with mem_ready_o.
- Undefined:
  - Port absent; addresses wrap modulo DEPTH_WORDS as above.

Test Plan:
- WAIT_CYCLES=2: write 0x1122_3344, mask 4'hF, addr 0x10 in cycle 0 -> busy high cycles 0-2; ready cycle 3 only. Then read 0x10 -> mem_data_o = 0x1122_3344 in its ready cycle.
- Byte write: word 0x1122_3344 at 0x20; write data 0xAABB_CCDD, mask 4'b0100 -> read returns 0x11BB_3344. Mask 4'b0000 -> word unchanged, ready still pulses.
- WAIT_CYCLES=0: read request cycle 0 -> ready and data valid cycle 1. Three back-to-back requests with req held -> ready in cycles 1, 3, 5.
- Reset asserted in WAIT during write of 0xDEAD_BEEF to 0x30 (prior 0x0) -> no ready pulse; mem_data_o = 0; read of 0x30 returns 0x0000_0000.
- DEPTH_WORDS=16, BASE_ADDR=0: write 0x5 to 0x40 -> read 0x00 returns 0x5 without RAM_RANGE_ERR_EN. With it: mem_err_o pulses, read 0x40 returns 0, word at 0x00 unchanged.
- Req toggled low after acceptance and addr changed during WAIT -> access uses the latched address; result is identical to the unchanged-input case.
